// File: rtl/mor1kx_bpred_pht_ctrl_pkg.sv
// rtl/mor1kx_bpred_pht_ctrl_pkg.sv - shared constants, state encoding and counter helper for the PHT controller
// Contents: 2-bit counter encodings, table init value, controller state enum,
// and the saturating counter step used by the update read-modify-write.
package mor1kx_bpred_pht_ctrl_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;  // strongly not taken
  localparam logic [1:0] CTR_WNT = 2'b01;  // weakly not taken
  localparam logic [1:0] CTR_WT  = 2'b10;  // weakly taken
  localparam logic [1:0] CTR_ST  = 2'b11;  // strongly taken

  localparam logic [1:0] PHT_INIT_VAL = CTR_WT;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_PRED_RD = 3'd2,
    ST_UPD_RD  = 3'd3,
    ST_UPD_WR  = 3'd4
  } ctrl_state_e;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    end
    return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/mor1kx_bpred_pht_ctrl_if.sv
// rtl/mor1kx_bpred_pht_ctrl_if.sv - lookup, update, table RAM and status signals of the PHT controller
// slave modport: controller view (lookup/update requests and RAM read data in).
// master modport: environment view (decode, branch resolution and the RAM).
interface mor1kx_bpred_pht_ctrl_if #(
  parameter int GSHARE_BITS_NUM      = 10,
  parameter int OPTION_OPERAND_WIDTH = 32
);

  logic                            pred_req_i;
  logic [OPTION_OPERAND_WIDTH-1:0] pred_pc_i;
  logic                            pred_ready_o;
  logic                            pred_valid_o;
  logic                            pred_taken_o;
  logic [GSHARE_BITS_NUM-1:0]      pred_idx_o;

  logic                            upd_valid_i;
  logic [GSHARE_BITS_NUM-1:0]      upd_idx_i;
  logic                            upd_taken_i;
  logic                            upd_ready_o;

  logic                            pht_en_o;
  logic                            pht_we_o;
  logic [GSHARE_BITS_NUM-1:0]      pht_addr_o;
  logic [1:0]                      pht_wdata_o;
  logic [1:0]                      pht_rdata_i;

  logic                            init_busy_o;

  modport slave (
    input  pred_req_i, pred_pc_i,
    output pred_ready_o, pred_valid_o, pred_taken_o, pred_idx_o,
    input  upd_valid_i, upd_idx_i, upd_taken_i,
    output upd_ready_o,
    output pht_en_o, pht_we_o, pht_addr_o, pht_wdata_o,
    input  pht_rdata_i,
    output init_busy_o
  );

  modport master (
    output pred_req_i, pred_pc_i,
    input  pred_ready_o, pred_valid_o, pred_taken_o, pred_idx_o,
    output upd_valid_i, upd_idx_i, upd_taken_i,
    input  upd_ready_o,
    input  pht_en_o, pht_we_o, pht_addr_o, pht_wdata_o,
    output pht_rdata_i,
    input  init_busy_o
  );

endinterface

// File: rtl/mor1kx_bpred_upd_fifo.sv
// rtl/mor1kx_bpred_upd_fifo.sv - small synchronous FIFO buffering resolved-branch updates
// Ports: clk, rst (async active-low); s_tvalid/s_tready/s_tdata write side
// (s_tready low means full); m_tvalid/m_tready/m_tdata read side (m_tvalid
// low means empty, m_tdata shows the head entry, m_tready pops it).
module mor1kx_bpred_upd_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic [WIDTH-1:0] s_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [WIDTH-1:0] m_tdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full, empty, push, pop;

  assign full     = (cnt_q == (AW+1)'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign push     = s_tvalid && !full;
  assign pop      = m_tready && !empty;
  assign s_tready = !full;
  assign m_tvalid = !empty;
  assign m_tdata  = mem_q[rd_ptr_q];

  // Depth is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_tdata;
    end
  end

endmodule

// File: rtl/mor1kx_bpred_pht_ctrl.sv
// rtl/mor1kx_bpred_pht_ctrl.sv - gshare PHT controller: init sweep, lookup/update arbitration, counter RMW, history
// Ports: clk, rst (async active-low), bus (slave modport): lookup request and
// 1-cycle prediction result, update push with ready, single-port RAM control
// with registered read data, and init_busy_o during the post-reset sweep.
module mor1kx_bpred_pht_ctrl
  import mor1kx_bpred_pht_ctrl_pkg::*;
#(
  parameter int GSHARE_BITS_NUM      = 10,
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int UPD_FIFO_DEPTH       = 2
) (
  input logic                     clk,
  input logic                     rst,
  mor1kx_bpred_pht_ctrl_if.slave  bus
);

  localparam int              G        = GSHARE_BITS_NUM;
  localparam logic [G-1:0]    IDX_LAST = '1;

  ctrl_state_e  state_q, state_d;
  logic [G-1:0] init_cnt_q, init_cnt_d;
  logic [G-1:0] hist_q, hist_d;
  logic [G-1:0] pidx_q, pidx_d;
  logic [1:0]   nxt_ctr_q, nxt_ctr_d;

  logic         fifo_ready, fifo_valid, fifo_full, fifo_pop;
  logic [G:0]   fifo_head;
  logic [G-1:0] head_idx;
  logic         head_taken;
  logic [G-1:0] lookup_idx;
  logic         idle_upd, idle_pred;

  logic unused_pc;
  assign unused_pc = ^{bus.pred_pc_i[OPTION_OPERAND_WIDTH-1:G+2], bus.pred_pc_i[1:0]};

  mor1kx_bpred_upd_fifo #(
    .WIDTH (G + 1),
    .DEPTH (UPD_FIFO_DEPTH)
  ) u_upd_fifo (
    .clk      (clk),
    .rst      (rst),
    .s_tvalid (bus.upd_valid_i && bus.upd_ready_o),
    .s_tready (fifo_ready),
    .s_tdata  ({bus.upd_idx_i, bus.upd_taken_i}),
    .m_tvalid (fifo_valid),
    .m_tready (fifo_pop),
    .m_tdata  (fifo_head)
  );

  assign fifo_full  = !fifo_ready;
  assign head_idx   = fifo_head[G:1];
  assign head_taken = fifo_head[0];
  assign lookup_idx = hist_q ^ bus.pred_pc_i[G+1:2];
  assign fifo_pop   = (state_q == ST_UPD_WR);

  // A full FIFO beats a lookup so resolution can never be starved by decode;
  // otherwise lookups win and updates fill the idle cycles.
  assign idle_upd  = fifo_full || (!bus.pred_req_i && fifo_valid);
  assign idle_pred = !fifo_full && bus.pred_req_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      hist_q     <= '0;
      pidx_q     <= '0;
      nxt_ctr_q  <= CTR_SNT;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      hist_q     <= hist_d;
      pidx_q     <= pidx_d;
      nxt_ctr_q  <= nxt_ctr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == IDX_LAST) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (idle_upd)       state_d = ST_UPD_RD;
        else if (idle_pred) state_d = ST_PRED_RD;
      end
      ST_PRED_RD: state_d = ST_IDLE;
      ST_UPD_RD:  state_d = ST_UPD_WR;
      ST_UPD_WR:  state_d = ST_IDLE;
      default:    state_d = ST_INIT;
    endcase
  end

  always_comb begin
    init_cnt_d = init_cnt_q;
    hist_d     = hist_q;
    pidx_d     = pidx_q;
    nxt_ctr_d  = nxt_ctr_q;
    if (state_q == ST_INIT) init_cnt_d = init_cnt_q + 1'b1;
    if (state_q == ST_IDLE && !idle_upd && idle_pred) pidx_d = lookup_idx;
    if (state_q == ST_UPD_RD) nxt_ctr_d = ctr_next(bus.pht_rdata_i, head_taken);
    if (state_q == ST_UPD_WR) hist_d = {hist_q[G-2:0], head_taken};
  end

  // Outputs are forced low while rst is held so the RAM sees no enable and
  // upstream sees no ready before the sweep actually starts.
  always_comb begin
    bus.pred_ready_o = 1'b0;
    bus.pred_valid_o = 1'b0;
    bus.pred_taken_o = 1'b0;
    bus.pred_idx_o   = '0;
    bus.upd_ready_o  = 1'b0;
    bus.pht_en_o     = 1'b0;
    bus.pht_we_o     = 1'b0;
    bus.pht_addr_o   = '0;
    bus.pht_wdata_o  = 2'b00;
    bus.init_busy_o  = 1'b1;
    if (rst) begin
      bus.upd_ready_o = fifo_ready;
      bus.init_busy_o = (state_q == ST_INIT);
      case (state_q)
        ST_INIT: begin
          bus.pht_en_o    = 1'b1;
          bus.pht_we_o    = 1'b1;
          bus.pht_addr_o  = init_cnt_q;
          bus.pht_wdata_o = PHT_INIT_VAL;
        end
        ST_IDLE: begin
          bus.pred_ready_o = !fifo_full;
          if (idle_upd) begin
            bus.pht_en_o   = 1'b1;
            bus.pht_addr_o = head_idx;
          end else if (idle_pred) begin
            bus.pht_en_o   = 1'b1;
            bus.pht_addr_o = lookup_idx;
          end
        end
        ST_PRED_RD: begin
          bus.pred_valid_o = 1'b1;
          bus.pred_taken_o = bus.pht_rdata_i[1];
          bus.pred_idx_o   = pidx_q;
        end
        ST_UPD_WR: begin
          bus.pht_en_o    = 1'b1;
          bus.pht_we_o    = 1'b1;
          bus.pht_addr_o  = head_idx;
          bus.pht_wdata_o = nxt_ctr_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mor1kx_bpred_pht_ctrl.sv
// tb/tb_mor1kx_bpred_pht_ctrl.sv - directed vector bench for the gshare PHT controller with a behavioural RAM
module tb_mor1kx_bpred_pht_ctrl;

  localparam int G = 4;

  typedef struct {
    logic        req;
    logic [31:0] pc;
    logic        uv;
    logic [3:0]  ui;
    logic        ut;
    logic        rdy;
    logic        pv;
    logic        pt;
    logic [3:0]  pi;
    logic        urdy;
    logic        en;
    logic        we;
    logic [3:0]  ad;
    logic [1:0]  wd;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec  = 0;
  int   n_fail = 0;
  logic [1:0] mem [16];
  vec_t vecs [37];

  mor1kx_bpred_pht_ctrl_if #(.GSHARE_BITS_NUM(G), .OPTION_OPERAND_WIDTH(32)) bus ();

  mor1kx_bpred_pht_ctrl #(
    .GSHARE_BITS_NUM(G), .OPTION_OPERAND_WIDTH(32), .UPD_FIFO_DEPTH(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.pht_en_o) begin
      if (bus.pht_we_o) mem[bus.pht_addr_o] <= bus.pht_wdata_o;
      else              bus.pht_rdata_i <= mem[bus.pht_addr_o];
    end
  end

  function automatic vec_t mk(logic req, logic [31:0] pc, logic uv, logic [3:0] ui, logic ut,
                              logic rdy, logic pv, logic pt, logic [3:0] pi, logic urdy,
                              logic en, logic we, logic [3:0] ad, logic [1:0] wd);
    vec_t v;
    v.req = req; v.pc = pc; v.uv = uv; v.ui = ui; v.ut = ut;
    v.rdy = rdy; v.pv = pv; v.pt = pt; v.pi = pi; v.urdy = urdy;
    v.en = en; v.we = we; v.ad = ad; v.wd = wd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic req, input logic [31:0] pc, input logic uv,
                       input logic [3:0] ui, input logic ut);
    bus.pred_req_i  = req;
    bus.pred_pc_i   = pc;
    bus.upd_valid_i = uv;
    bus.upd_idx_i   = ui;
    bus.upd_taken_i = ut;
  endtask

  task automatic chk_sweep(input string tag, input int i);
    chk($sformatf("%s[%0d].busy", tag, i), 32'(bus.init_busy_o), 32'd1);
    chk($sformatf("%s[%0d].en",   tag, i), 32'(bus.pht_en_o),    32'd1);
    chk($sformatf("%s[%0d].we",   tag, i), 32'(bus.pht_we_o),    32'd1);
    chk($sformatf("%s[%0d].addr", tag, i), 32'(bus.pht_addr_o),  32'(i));
    chk($sformatf("%s[%0d].wd",   tag, i), 32'(bus.pht_wdata_o), 32'd2);
    chk($sformatf("%s[%0d].rdy",  tag, i), 32'(bus.pred_ready_o), 32'd0);
  endtask

  task automatic chk_ram(input string tag, input logic en, input logic we,
                         input logic [3:0] ad, input logic [1:0] wd);
    chk({tag, ".en"},   32'(bus.pht_en_o),    32'(en));
    chk({tag, ".we"},   32'(bus.pht_we_o),    32'(we));
    chk({tag, ".addr"}, 32'(bus.pht_addr_o),  32'(ad));
    chk({tag, ".wd"},   32'(bus.pht_wdata_o), 32'(wd));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            req pc     uv ui ut   rdy pv pt pi urdy en we ad wd
    vecs[0]  = mk(1, 32'h40, 0, 0, 0,   1,  0, 0, 0, 1,   1, 0, 0, 0);
    vecs[1]  = mk(0, 32'h00, 0, 0, 0,   0,  1, 1, 0, 1,   0, 0, 0, 0);
    vecs[2]  = mk(0, 32'h00, 1, 5, 1,   1,  0, 0, 0, 1,   0, 0, 0, 0);
    vecs[3]  = mk(0, 32'h00, 1, 5, 1,   1,  0, 0, 0, 1,   1, 0, 5, 0);
    vecs[4]  = mk(0, 32'h00, 0, 0, 0,   0,  0, 0, 0, 0,   0, 0, 0, 0);
    vecs[5]  = mk(0, 32'h00, 1, 9, 0,   0,  0, 0, 0, 0,   1, 1, 5, 3);
    vecs[6]  = mk(0, 32'h00, 1, 5, 1,   1,  0, 0, 0, 1,   1, 0, 5, 0);
    vecs[7]  = mk(0, 32'h00, 0, 0, 0,   0,  0, 0, 0, 0,   0, 0, 0, 0);
    vecs[8]  = mk(0, 32'h00, 0, 0, 0,   0,  0, 0, 0, 0,   1, 1, 5, 3);
    vecs[9]  = mk(0, 32'h00, 0, 0, 0,   1,  0, 0, 0, 1,   1, 0, 5, 0);
    vecs[10] = mk(0, 32'h00, 0, 0, 0,   0,  0, 0, 0, 1,   0, 0, 0, 0);
    vecs[11] = mk(0, 32'h00, 0, 0, 0,   0,  0, 0, 0, 1,   1, 1, 5, 3);
    vecs[12] = mk(1, 32'h08, 0, 0, 0,   1,  0, 0, 0, 1,   1, 0, 5, 0);
    vecs[13] = mk(0, 32'h00, 0, 0, 0,   0,  1, 1, 5, 1,   0, 0, 0, 0);
    vecs[14] = mk(0, 32'h00, 1, 3, 0,   1,  0, 0, 0, 1,   0, 0, 0, 0);
    vecs[15] = mk(0, 32'h00, 1, 3, 0,   1,  0, 0, 0, 1,   1, 0, 3, 0);
    vecs[16] = mk(0, 32'h00, 0, 0, 0,   0,  0, 0, 0, 0,   0, 0, 0, 0);
    vecs[17] = mk(0, 32'h00, 0, 0, 0,   0,  0, 0, 0, 0,   1, 1, 3, 1);
    vecs[18] = mk(0, 32'h00, 1, 3, 0,   1,  0, 0, 0, 1,   1, 0, 3, 0);
    vecs[19] = mk(0, 32'h00, 0, 0, 0,   0,  0, 0, 0, 0,   0, 0, 0, 0);
    vecs[20] = mk(0, 32'h00, 0, 0, 0,   0,  0, 0, 0, 0,   1, 1, 3, 0);
    vecs[21] = mk(0, 32'h00, 0, 0, 0,   1,  0, 0, 0, 1,   1, 0, 3, 0);
    vecs[22] = mk(0, 32'h00, 0, 0, 0,   0,  0, 0, 0, 1,   0, 0, 0, 0);
    vecs[23] = mk(0, 32'h00, 0, 0, 0,   0,  0, 0, 0, 1,   1, 1, 3, 0);
    vecs[24] = mk(1, 32'h2C, 0, 0, 0,   1,  0, 0, 0, 1,   1, 0, 3, 0);
    vecs[25] = mk(0, 32'h00, 0, 0, 0,   0,  1, 0, 3, 1,   0, 0, 0, 0);
    vecs[26] = mk(1, 32'h00, 1, 1, 1,   1,  0, 0, 0, 1,   1, 0, 8, 0);
    vecs[27] = mk(1, 32'h00, 1, 2, 0,   0,  1, 1, 8, 1,   0, 0, 0, 0);
    vecs[28] = mk(1, 32'h00, 0, 0, 0,   0,  0, 0, 0, 0,   1, 0, 1, 0);
    vecs[29] = mk(1, 32'h00, 0, 0, 0,   0,  0, 0, 0, 0,   0, 0, 0, 0);
    vecs[30] = mk(1, 32'h00, 0, 0, 0,   0,  0, 0, 0, 0,   1, 1, 1, 3);
    vecs[31] = mk(1, 32'h00, 0, 0, 0,   1,  0, 0, 0, 1,   1, 0, 1, 0);
    vecs[32] = mk(0, 32'h00, 0, 0, 0,   0,  1, 1, 1, 1,   0, 0, 0, 0);
    vecs[33] = mk(0, 32'h00, 0, 0, 0,   1,  0, 0, 0, 1,   1, 0, 2, 0);
    vecs[34] = mk(0, 32'h00, 0, 0, 0,   0,  0, 0, 0, 1,   0, 0, 0, 0);
    vecs[35] = mk(0, 32'h00, 0, 0, 0,   0,  0, 0, 0, 1,   1, 1, 2, 1);
    vecs[36] = mk(0, 32'h00, 0, 0, 0,   1,  0, 0, 0, 1,   0, 0, 0, 0);

    drive(0, 32'h0, 0, 0, 0);

    // Reset held: only init_busy_o is high.
    @(negedge clk); #1;
    chk("rst.busy",  32'(bus.init_busy_o),  32'd1);
    chk("rst.pv",    32'(bus.pred_valid_o), 32'd0);
    chk("rst.rdy",   32'(bus.pred_ready_o), 32'd0);
    chk("rst.urdy",  32'(bus.upd_ready_o),  32'd0);
    chk_ram("rst", 0, 0, 0, 0);

    // Init sweep: 16 writes of weakly-taken, addresses 0..15.
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      chk_sweep("init", i);
    end
    @(negedge clk); #1;
    chk("post_init.busy", 32'(bus.init_busy_o),  32'd0);
    chk("post_init.rdy",  32'(bus.pred_ready_o), 32'd1);
    chk("post_init.en",   32'(bus.pht_en_o),     32'd0);

    for (int i = 0; i < 37; i++) begin
      @(negedge clk);
      drive(vecs[i].req, vecs[i].pc, vecs[i].uv, vecs[i].ui, vecs[i].ut);
      #1;
      chk($sformatf("v%0d.rdy",  i), 32'(bus.pred_ready_o), 32'(vecs[i].rdy));
      chk($sformatf("v%0d.pv",   i), 32'(bus.pred_valid_o), 32'(vecs[i].pv));
      chk($sformatf("v%0d.pt",   i), 32'(bus.pred_taken_o), 32'(vecs[i].pt));
      chk($sformatf("v%0d.pidx", i), 32'(bus.pred_idx_o),   32'(vecs[i].pi));
      chk($sformatf("v%0d.urdy", i), 32'(bus.upd_ready_o),  32'(vecs[i].urdy));
      chk($sformatf("v%0d.busy", i), 32'(bus.init_busy_o),  32'd0);
      chk_ram($sformatf("v%0d", i), vecs[i].en, vecs[i].we, vecs[i].ad, vecs[i].wd);
    end

    // Reset in the middle of an update read.
    @(negedge clk); drive(0, 32'h0, 1, 4, 1); #1;
    chk_ram("r0", 0, 0, 0, 0);
    @(negedge clk); drive(0, 32'h0, 0, 0, 0); #1;
    chk_ram("r1", 1, 0, 4, 0);
    @(negedge clk); #1;
    chk_ram("r2_updrd", 0, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    chk("rmid.busy", 32'(bus.init_busy_o),  32'd1);
    chk("rmid.urdy", 32'(bus.upd_ready_o),  32'd0);
    chk("rmid.rdy",  32'(bus.pred_ready_o), 32'd0);
    chk("rmid.pv",   32'(bus.pred_valid_o), 32'd0);
    chk_ram("rmid", 0, 0, 0, 0);

    // Sweep restarts at 0; an update queued mid-sweep waits for it to end.
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i != 0) @(negedge clk);
      drive(0, 32'h0, (i == 2), 6, 0);
      #1;
      chk_sweep("reinit", i);
      if (i == 2) chk("reinit.urdy", 32'(bus.upd_ready_o), 32'd1);
    end
    @(negedge clk); drive(0, 32'h0, 0, 0, 0); #1;
    chk("q.busy", 32'(bus.init_busy_o), 32'd0);
    chk_ram("q.rd", 1, 0, 6, 0);
    @(negedge clk); #1;
    chk_ram("q.updrd", 0, 0, 0, 0);
    @(negedge clk); #1;
    chk_ram("q.wr", 1, 1, 6, 1);
    @(negedge clk); #1;
    chk_ram("q.empty", 0, 0, 0, 0);
    @(negedge clk); drive(1, 32'h10, 0, 0, 0); #1;
    chk("q.lk.rdy", 32'(bus.pred_ready_o), 32'd1);
    chk_ram("q.lk", 1, 0, 4, 0);
    @(negedge clk); drive(0, 32'h0, 0, 0, 0); #1;
    chk("q.res.pv",   32'(bus.pred_valid_o), 32'd1);
    chk("q.res.pt",   32'(bus.pred_taken_o), 32'd1);
    chk("q.res.pidx", 32'(bus.pred_idx_o),   32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mor1kx_bpred_pht_ctrl.md
Name: mor1kx_bpred_pht_ctrl

Overview:
Controller for a gshare pattern history table (PHT) held in an external single-port 1R/1W synchronous RAM.
- Sequences the post-reset table initialisation sweep.
- Arbitrates table access between prediction lookups from decode and counter updates from branch resolution.
- Buffers resolved-branch updates in a small FIFO, performs the 2-bit saturating read-modify-write, and owns the global history register.

Parameters:
GSHARE_BITS_NUM, 10, index width; table has 2**GSHARE_BITS_NUM 2-bit counters
OPTION_OPERAND_WIDTH, 32, PC width
UPD_FIFO_DEPTH, 2, update FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
pred_req_i  in  1  lookup request (cond branch in decode)
pred_pc_i  in  OPTION_OPERAND_WIDTH  PC of branch
pred_ready_o  out  1  lookup accepted this cycle when high with pred_req_i
pred_valid_o  out  1  prediction result valid (one-cycle pulse)
pred_taken_o  out  1  predicted direction (counter MSB)
pred_idx_o  out  GSHARE_BITS_NUM  table index used; carried down pipe for update
upd_valid_i  in  1  resolved branch update
upd_idx_i  in  GSHARE_BITS_NUM  index returned from pred_idx_o
upd_taken_i  in  1  actual outcome
upd_ready_o  out  1  update FIFO not full
pht_en_o  out  1  RAM enable
pht_we_o  out  1  RAM write enable
pht_addr_o  out  GSHARE_BITS_NUM  RAM address
pht_wdata_o  out  2  RAM write data
pht_rdata_i  in  2  RAM read data, valid cycle after read enable
init_busy_o  out  1  init sweep in progress

Behaviour:
- Reset (rst low, async): state=INIT, init counter=0, history=0, FIFO empty. All outputs 0 except init_busy_o=1. Reset during any state aborts it; sweep restarts from index 0 after release.
- Counter encoding: 00 strongly NT, 01 weakly NT, 10 weakly T, 11 strongly T. Init value is 10.
- INIT:
  - Each cycle: pht_en_o=1, pht_we_o=1, addr=counter, wdata=10; counter increments.
  - After writing index 2**G-1: go IDLE; init_busy_o falls that cycle edge.
  - Sweep takes exactly 2**G cycles. pred_ready_o=0 throughout.
  - upd_ready_o follows FIFO fullness; queued updates wait for the sweep to finish.
- IDLE arbitration, priority:
  - (a) FIFO full: start update.
  - (b) pred_req_i: start lookup.
  - (c) FIFO non-empty: start update.
  - (d) otherwise idle, pht_en_o=0.
  - pred_ready_o = (state==IDLE) && !fifo_full.
- Lookup:
  - Accept cycle: addr = history XOR pred_pc_i[G+1:2], en=1, we=0. Index registered; go PRED_RD.
  - PRED_RD (next cycle): pred_valid_o=1, pred_taken_o=pht_rdata_i[1], pred_idx_o=registered index. Return IDLE.
  - Latency: request to result is 1 cycle. Throughput: one lookup per 2 cycles.
- Update:
  - Issue read of head.idx; go UPD_RD.
  - UPD_RD: compute next counter (taken: +1 saturating at 11; not taken: -1 saturating at 00); go UPD_WR.
  - UPD_WR: en=1, we=1, addr=head.idx, wdata=next. Pop FIFO. history <= {history[G-2:0], head.taken}. Return IDLE.
  - Updates occupy 3 cycles and are strictly serialised, so there is no RMW hazard.
- FIFO:
  - Push when upd_valid_i && upd_ready_o. Push and pop in the same cycle are both honoured.
  - upd_valid_i while full is dropped. Upstream must hold it while upd_ready_o is low.
  - Pointers wrap modulo depth; count is width clog2(depth)+1.
- Lookups see pre-update table contents. A lookup and an update to the same index are not forwarded.
- pred_valid_o, pht_en_o and pht_we_o are never X after reset.

Decomposition:
- Shared package/defines:
  - Counter state constants (SNT/WNT/WT/ST).
  - Controller state encoding (INIT, IDLE, PRED_RD, UPD_RD, UPD_WR).
  - PHT init value constant.
- Sub-module: mor1kx_bpred_upd_fifo, a parameterised synchronous FIFO of {idx, taken} with full/empty.

Test Plan:
- Reset release, G=4 -> init_busy_o high 16 cycles; writes addr 0..15 wdata 10; then IDLE, pred_ready_o=1.
- After init, pred_req_i with PC 0x40, history 0 -> addr 0x0; next cycle pred_valid_o=1, pred_taken_o=1, pred_idx_o=0.
- Three taken updates to idx 5 -> counter 10->11->11 saturates; history becomes 0b111; later lookup idx 5 predicts taken.
- Three not-taken updates to idx 3 from 10 -> 01, 00, 00; lookup predicts not taken.
- Fill FIFO (2 updates) while pred_req_i held high -> upd_ready_o=0 and pred_ready_o=0; update serviced first, then lookup accepted; third update dropped only if asserted without ready.
- Assert rst low mid-UPD_RD -> outputs clear immediately; FIFO empty; sweep restarts at addr 0 after release.
